// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler for a shared 8:1 bit-select mux.
// Registers the owner index (S), a one-hot grant (GNT) and VALID; the owner
// keeps the mux until DONE, withdrawal of its request, or (optionally) timeout.
// Optional feature macro: SCHED_TIMEOUT_EN -- revoke an owner after MAX_HOLD
// GRANT cycles. Without it the hold counter is not built and MAX_HOLD is only
// range-checked.
module mux8_rr_sched #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] REQ,
    input  logic       DONE,
    output logic [2:0] S,
    output logic [7:0] GNT,
    output logic       VALID
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Elaboration-time guard on the hold limit.
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux8_rr_sched: MAX_HOLD must be in 1..255");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   s_d;
    logic [N_REQ-1:0]   gnt_d;
    logic               valid_d;
    logic [IDX_W-1:0]   win_idx_c;
    logic               win_vld_c;
    logic               timeout_c;
    logic               release_c;

`ifdef SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Owner has used its last allowed GRANT cycle.
    assign timeout_c = (cnt_q == HOLD_LAST);
`else
    assign timeout_c = 1'b0;
`endif

    // Cyclic search from ptr; walking offsets high-to-low lets the nearest hit win.
    always_comb begin
        win_idx_c = '0;
        win_vld_c = 1'b0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (REQ[ptr_q + IDX_W'(i)]) begin
                win_idx_c = ptr_q + IDX_W'(i);
                win_vld_c = 1'b1;
            end
        end
    end

    // Any release cause ends the grant; coincident causes collapse into one.
    assign release_c = DONE | ~REQ[S] | timeout_c;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = S;
        gnt_d   = GNT;
        valid_d = VALID;
`ifdef SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld_c) begin
                    state_d = GRANT;
                    s_d     = win_idx_c;
                    gnt_d   = N_REQ'(1) << win_idx_c;
                    valid_d = 1'b1;
`ifdef SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = S + IDX_W'(1);
`ifdef SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
`ifdef SCHED_TIMEOUT_EN
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            S       <= '0;
            GNT     <= '0;
            VALID   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            S       <= s_d;
            GNT     <= gnt_d;
            VALID   <= valid_d;
`ifdef SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched: vector table plus hand sequences,
// expectations queued at drive time and popped after the clock edge.
module tb_mux8_rr_sched;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [2:0] s;
        logic [7:0] gnt;
        logic       valid;
    } vec_t;

    typedef struct {
        logic [2:0] s;
        logic [7:0] gnt;
        logic       valid;
    } exp_t;

    logic       CLK;
    logic       RST_N;
    logic [7:0] REQ;
    logic       DONE;
    logic [2:0] S;
    logic [7:0] GNT;
    logic       VALID;

    int n_cmp = 0;
    int n_err = 0;

    vec_t tbl[$];
    exp_t exp_q[$];

    mux8_rr_sched #(.MAX_HOLD(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .DONE  (DONE),
        .S     (S),
        .GNT   (GNT),
        .VALID (VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pop one expectation and compare all outputs against it.
    task automatic check_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got no expectation required one", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".S"},      8'(S),     8'(e.s));
        check({tag, ".GNT"},    GNT,       e.gnt);
        check({tag, ".VALID"},  8'(VALID), 8'(e.valid));
        check({tag, ".onehot"}, 8'($onehot0(GNT)), 8'd1);
    endtask

    // Called just after a falling edge: drive, queue expectation, sample after rise.
    task automatic step(input string tag, input logic [7:0] req, input logic done,
                        input logic [2:0] s, input logic [7:0] gnt, input logic valid);
        exp_t e;
        REQ  = req;
        DONE = done;
        e.s = s; e.gnt = gnt; e.valid = valid;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        check_outputs(tag);
        @(negedge CLK);
    endtask

    initial begin
        logic [2:0] idx;
        logic       v;

        // Round-robin sweep: grant n, release with DONE, next grant n+1, wrapping to 0.
        for (int n = 0; n <= 8; n++) begin
            idx = 3'(n % 8);
            tbl.push_back('{8'hFF, 1'b0, idx, 8'(8'd1 << idx), 1'b1});
            tbl.push_back('{8'hFF, 1'b1, idx, 8'h00, 1'b0});
        end
        // Move pointer to 6, then wrap-and-skip: REQ=05 picks 0, then 2 (ptr became 1).
        tbl.push_back('{8'h20, 1'b0, 3'd5, 8'h20, 1'b1});
        tbl.push_back('{8'h20, 1'b1, 3'd5, 8'h00, 1'b0});
        tbl.push_back('{8'h05, 1'b0, 3'd0, 8'h01, 1'b1});
        tbl.push_back('{8'h05, 1'b1, 3'd0, 8'h00, 1'b0});
        tbl.push_back('{8'h05, 1'b0, 3'd2, 8'h04, 1'b1});
        tbl.push_back('{8'h00, 1'b0, 3'd2, 8'h00, 1'b0});
        // Owner withdraw: grant 3, others appear without effect, 3 drops, then 4 wins.
        tbl.push_back('{8'h08, 1'b0, 3'd3, 8'h08, 1'b1});
        tbl.push_back('{8'h38, 1'b0, 3'd3, 8'h08, 1'b1});
        tbl.push_back('{8'h30, 1'b0, 3'd3, 8'h00, 1'b0});
        tbl.push_back('{8'h30, 1'b0, 3'd4, 8'h10, 1'b1});
        tbl.push_back('{8'h00, 1'b0, 3'd4, 8'h00, 1'b0});
        tbl.push_back('{8'h00, 1'b0, 3'd4, 8'h00, 1'b0});
        // DONE with withdrawal counts once: pointer advances by exactly one.
        tbl.push_back('{8'h40, 1'b0, 3'd6, 8'h40, 1'b1});
        tbl.push_back('{8'h00, 1'b1, 3'd6, 8'h00, 1'b0});
        tbl.push_back('{8'hC0, 1'b0, 3'd7, 8'h80, 1'b1});
        tbl.push_back('{8'hC0, 1'b1, 3'd7, 8'h00, 1'b0});
        tbl.push_back('{8'hC0, 1'b0, 3'd6, 8'h40, 1'b1});
        tbl.push_back('{8'hC0, 1'b1, 3'd6, 8'h00, 1'b0});

        // Reset held with all requests active.
        RST_N = 1'b0;
        REQ   = 8'hFF;
        DONE  = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset.S",     8'(S),     8'h00);
        check("reset.GNT",   GNT,       8'h00);
        check("reset.VALID", 8'(VALID), 8'h00);
        RST_N = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].req, tbl[i].done,
                 tbl[i].s, tbl[i].gnt, tbl[i].valid);
        end

        // Hold REQ=02 with DONE low; pointer is 7 so index 1 wins each time.
        for (int k = 0; k < 110; k++) begin
`ifdef SCHED_TIMEOUT_EN
            v = (k % 5) != 4;
`else
            v = 1'b1;
`endif
            step($sformatf("hold%0d", k), 8'h02, 1'b0, 3'd1, v ? 8'h02 : 8'h00, v);
        end
        step("hold_end", 8'h00, 1'b0, 3'd1, 8'h00, 1'b0);

        // Async reset mid-grant: outputs clear before the next edge, pointer restarts.
        step("pre_rst", 8'h20, 1'b0, 3'd5, 8'h20, 1'b1);
        #2;
        RST_N = 1'b0;
        REQ   = 8'h21;
        #1;
        check("async_rst.S",     8'(S),     8'h00);
        check("async_rst.GNT",   GNT,       8'h00);
        check("async_rst.VALID", 8'(VALID), 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        step("post_rst", 8'h21, 1'b0, 3'd0, 8'h01, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
